// File: rtl/spectrum_uart_tx.sv
// spectrum_uart_tx: 8N1 serial transmitter for spectrum frames.
// Each frame is SYNC_BYTE followed by FRAME_LEN data bytes.
module spectrum_uart_tx #(
    parameter int         CLKS_PER_BIT = 16,
    parameter int         FRAME_LEN    = 8,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         GAP_CYCLES   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    // The baud counter also times GAP, so size it for the larger of the two.
    localparam int MAXC = (CLKS_PER_BIT > GAP_CYCLES) ? CLKS_PER_BIT : GAP_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int BW   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [BW-1:0] CNT_LAST  = BW'(FRAME_LEN - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    logic [2:0]    state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic [BW-1:0] byte_cnt;
    logic          is_sync;
    logic          baud_last;

    assign baud_last = (baud_cnt == BAUD_LAST);

    // Frame sequencer: all outputs are registered, and the shift byte is
    // only written when a byte is latched (IDLE start or after a sync byte).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            byte_cnt   <= '0;
            is_sync    <= 1'b0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        state    <= S_START;
                        busy     <= 1'b1;
                        tx       <= 1'b0;
                        baud_cnt <= '0;
                        if (byte_cnt == '0) begin
                            shift   <= SYNC_BYTE;
                            is_sync <= 1'b1;
                        end else begin
                            shift   <= data;
                            is_sync <= 1'b0;
                        end
                    end
                end
                S_START: begin
                    if (baud_last) begin
                        state    <= S_DATA;
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shift[bit_idx + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (is_sync) begin
                            // Sync and its data byte go out back to back.
                            shift   <= data;
                            is_sync <= 1'b0;
                            state   <= S_START;
                            tx      <= 1'b0;
                        end else begin
                            busy  <= 1'b0;
                            state <= S_GAP;
                            if (byte_cnt == CNT_LAST) begin
                                byte_cnt   <= '0;
                                frame_done <= 1'b1;
                            end else begin
                                byte_cnt <= byte_cnt + BW'(1);
                            end
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                S_GAP: begin
                    // Gives upstream time to present the next byte.
                    if (baud_cnt == GAP_LAST) begin
                        state    <= S_IDLE;
                        baud_cnt <= '0;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    baud_cnt <= '0;
                    tx       <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spectrum_uart_tx.sv
// tb_spectrum_uart_tx: directed vectors plus randomized traffic
// checked by a serial receiver and a frame-level byte model.
module tb_spectrum_uart_tx;

    localparam int CPB = 4;
    localparam int FL  = 2;
    localparam int GAP = 2;
    localparam logic [7:0] SYNC = 8'hA5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [7:0] data;
    logic       tx;
    logic       busy;
    logic       frame_done;

    spectrum_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FRAME_LEN   (FL),
        .SYNC_BYTE   (SYNC),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .data      (data),
        .tx        (tx),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] din;
        int         nbytes;
        logic [7:0] b0;
        logic [7:0] b1;
        bit         fd;
    } vec_t;

    vec_t tbl [4];

    // Reference model state (byte level)
    logic [7:0] q[$];
    int  pos;
    int  exp_fd;
    int  fd_cnt;
    int  fd_bad;
    int  falls;
    int  rx_cnt;
    bit  pb;
    bit  mon_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Waits for busy to rise, then captures the whole busy window and
    // compares tx cycle by cycle against the ideal 8N1 waveform.
    task automatic run_txn(input logic [7:0] b0, input logic [7:0] b1,
                           input int nb, input bit exp_fd_pulse,
                           input int drop_at, input string tag,
                           output int gap);
        bit exp_w [200];
        int k, n, errs, w;
        logic [7:0] bv;
        k = 0;
        for (int by = 0; by < nb; by++) begin
            bv = (by == 0) ? b0 : b1;
            for (int p = 0; p < 10; p++)
                for (int c = 0; c < CPB; c++) begin
                    exp_w[k] = (p == 0) ? 1'b0 : (p == 9) ? 1'b1 : bv[p-1];
                    k++;
                end
        end
        w = 0;
        while (!busy && w < 200) begin
            @(negedge clk);
            w++;
        end
        gap = w;
        if (!busy) begin
            check({tag, "_timeout"}, 1, 0);
            return;
        end
        n = 0;
        errs = 0;
        while (busy && n < 200) begin
            if (n == drop_at) enable = 1'b0;
            if (n >= k || tx !== exp_w[n]) errs++;
            n++;
            @(negedge clk);
        end
        check({tag, "_busy_len"}, n, k);
        check({tag, "_wave_errs"}, errs, 0);
        check({tag, "_frame_done"}, frame_done, exp_fd_pulse);
    endtask

    // One cycle of the randomized phases: model update on busy edges.
    task automatic step();
        @(negedge clk);
        if (busy && !pb) begin
            if (pos == 0) q.push_back(SYNC);
            q.push_back(data);
            pos = (pos + 1) % FL;
            if (pos == 0) exp_fd++;
        end
        if (frame_done) begin
            fd_cnt++;
            if (!(pb && !busy)) fd_bad++;
        end
        if (!busy && pb) begin
            falls++;
            data = 8'($urandom);
        end
        pb = busy;
    endtask

    // Serial receiver: samples each bit near its centre.
    initial begin
        logic [7:0] b;
        logic [7:0] e;
        logic       stp;
        forever begin
            @(negedge clk);
            if (mon_on && rst_n && tx === 1'b0) begin
                for (int j = 1; j <= 9; j++) begin
                    repeat ((j == 1) ? 6 : 4) @(negedge clk);
                    if (j <= 8) b[j-1] = tx;
                    else stp = tx;
                end
                if (q.size() == 0) begin
                    check("rx_unexpected_byte", {24'd0, b}, 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    check("rx_byte", b, e);
                end
                check("rx_stop", stp, 1);
                rx_cnt++;
            end
        end
    end

    initial begin
        int g;
        int quiet;
        tbl[0] = '{8'h3C, 2, SYNC, 8'h3C, 1'b0};
        tbl[1] = '{8'h81, 1, 8'h81, 8'h00, 1'b1};
        tbl[2] = '{8'h5A, 2, SYNC, 8'h5A, 1'b0};
        tbl[3] = '{8'hC3, 1, 8'hC3, 8'h00, 1'b1};

        rst_n  = 1'b0;
        enable = 1'b0;
        data   = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);

        data   = tbl[0].din;
        enable = 1'b1;
        rst_n  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_txn(tbl[i].b0, tbl[i].b1, tbl[i].nbytes, tbl[i].fd, -1,
                    $sformatf("vec%0d", i), g);
            check($sformatf("vec%0d_gap", i), g, (i == 0) ? 1 : GAP + 1);
            if (i < 3) data = tbl[i+1].din;
        end

        // Enable dropped 5 cycles into a sync byte: pair still completes.
        data = 8'h6E;
        run_txn(SYNC, 8'h6E, 2, 1'b0, 5, "drop", g);
        data = 8'h77;
        quiet = 0;
        repeat (100) begin
            @(negedge clk);
            if (busy !== 1'b0 || tx !== 1'b1 || frame_done !== 1'b0) quiet++;
        end
        check("drop_idle_activity", quiet, 0);

        // Re-enable resumes the frame without a new sync.
        enable = 1'b1;
        run_txn(8'h77, 8'h00, 1, 1'b1, -1, "resume", g);
        check("resume_gap", g, 1);
        data = 8'h12;
        run_txn(SYNC, 8'h12, 2, 1'b0, -1, "pair2", g);
        data = 8'h37;

        // Reset in DATA bit 3 of a mid-frame data byte.
        g = 0;
        while (!busy && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("rst_mid_started", busy, 1);
        repeat (18) @(negedge clk);
        check("pre_rst_tx_bit3", tx, 0);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_tx", tx, 1);
        check("async_rst_busy", busy, 0);
        check("async_rst_fd", frame_done, 0);
        data = 8'h4B;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(SYNC, 8'h4B, 2, 1'b0, -1, "post_rst", g);
        check("post_rst_gap", g, 1);

        // Three full frames with continuous enable.
        rst_n  = 1'b0;
        q.delete();
        pos    = 0;
        exp_fd = 0;
        fd_cnt = 0;
        fd_bad = 0;
        falls  = 0;
        rx_cnt = 0;
        pb     = 1'b0;
        data   = 8'($urandom);
        enable = 1'b1;
        mon_on = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        g = 0;
        while (falls < 6 && g < 3000) begin
            step();
            g++;
            if (falls == 6) enable = 1'b0;
        end
        repeat (20) step();
        check("frames3_busy_falls", falls, 6);
        check("frames3_frame_done", fd_cnt, 3);
        check("frames3_rx_bytes", rx_cnt, 9);
        check("frames3_fd_placement", fd_bad, 0);
        check("frames3_queue_left", q.size(), 0);

        // Random enable toggling against the byte model.
        enable = 1'b1;
        repeat (3000) begin
            if ($urandom_range(0, 15) == 0) enable = ~enable;
            step();
        end
        enable = 1'b0;
        repeat (150) step();
        check("rand_queue_left", q.size(), 0);
        check("rand_frame_done", fd_cnt, exp_fd);
        check("rand_fd_placement", fd_bad, 0);
        check("rand_end_tx", tx, 1);
        check("rand_end_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spectrum_uart_tx.md
SPECTRUM_UART_TX -- requirements
Module: spectrum_uart_tx

Interface
REQ-001 The module SHALL have a parameter CLKS_PER_BIT, default 16, giving the clk cycles per UART bit (minimum 2).
REQ-002 The module SHALL have a parameter FRAME_LEN, default 8, giving the data bytes per spectrum frame (minimum 1).
REQ-003 The module SHALL have a parameter SYNC_BYTE, default 8'hA5, giving the header byte sent before each frame.
REQ-004 The module SHALL have a parameter GAP_CYCLES, default 2, giving the idle clk cycles after a data byte before the next fetch (minimum 1).
REQ-005 Port clk, input, 1 bit: the single clock; all logic is rising-edge except the reset.
REQ-006 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 Port enable, input, 1 bit: high permits new bytes to start.
REQ-008 Port data, input, 8 bits: next spectrum byte, driven by the upstream transform block; stable whenever busy is low.
REQ-009 Port tx, output, 1 bit: serial line, idle high, 8N1, LSB first.
REQ-010 Port busy, output, 1 bit: high while a byte (or a sync+data pair) is in flight; its falling edge requests the next data byte from upstream.
REQ-011 Port frame_done, output, 1 bit: one-cycle pulse marking the end of a frame.

Function
REQ-012 The module SHALL use the states IDLE, START, DATA, STOP and GAP.
REQ-013 In IDLE, tx=1 and busy=0, and when enable is sampled high the module SHALL, on that same edge, enter START, set busy=1, drive tx=0 and latch the shift byte.
REQ-014 The latched byte SHALL be SYNC_BYTE with is_sync=1 when byte_cnt==0; otherwise it SHALL be data with is_sync=0.
REQ-015 START SHALL hold tx=0 for exactly CLKS_PER_BIT cycles.
REQ-016 DATA SHALL send bits [0] through [7], each for CLKS_PER_BIT cycles.
REQ-017 STOP SHALL hold tx=1 for CLKS_PER_BIT cycles, so one byte occupies 10*CLKS_PER_BIT cycles from the tx falling edge to the end of STOP.
REQ-018 At the end of STOP with is_sync=1, the module SHALL latch data, clear is_sync and enter START directly, with busy held high (no busy falling edge after a sync byte) and no idle cycle between the sync stop bit and the next start bit.
REQ-019 At the end of STOP with is_sync=0, the module SHALL set busy=0, update byte_cnt and enter GAP.
REQ-020 The byte_cnt update SHALL increment byte_cnt, or, if byte_cnt==FRAME_LEN-1, SHALL set byte_cnt=0 and pulse frame_done high for exactly that one cycle.
REQ-021 GAP SHALL last GAP_CYCLES cycles with busy=0 and tx=1, then the module SHALL return to IDLE, so data is never sampled earlier than GAP_CYCLES+1 cycles after busy falls.
REQ-022 When FRAME_LEN=1, every data byte SHALL be preceded by a sync byte, and frame_done SHALL pulse after each data byte.
REQ-023 Enable is examined only in IDLE; deasserting it mid-byte or mid-pair SHALL NOT truncate the byte or pair, and the module SHALL then remain in IDLE with byte_cnt preserved (the frame resumes on re-enable without a new sync).
REQ-024 A single 16-bit-or-smaller baud counter SHALL count 0..CLKS_PER_BIT-1, reset to 0 on every state change, with a 3-bit bit index for DATA.
REQ-025 The shift register SHALL NOT change outside a latch event.
REQ-026 tx, busy and frame_done SHALL be registered outputs (glitch-free).

Reset
REQ-027 When rst_n=0, the module SHALL immediately and asynchronously set tx=1, busy=0, frame_done=0, state=IDLE, byte_cnt=0, is_sync=0, baud counter=0, bit index=0 and shift register=0.
REQ-028 Reset mid-byte SHALL abandon the byte; after release, the first byte sent SHALL be SYNC_BYTE.
REQ-029 The module SHALL take no action on the first rising edge coincident with rst_n release unless enable is high, in which case normal IDLE rules SHALL apply.

Verification (CLKS_PER_BIT=4, FRAME_LEN=2, GAP_CYCLES=2)
REQ-030 Reset then enable=1, data=8'h3C -> tx waveform 0,1,0,1,0,0,1,0,1,1 (8'hA5 LSB first, 4 cycles/bit), then 0,0,0,1,1,1,1,0,0,1 (8'h3C), with busy high continuously for 80 cycles, then falling.
REQ-031 Upstream changes data to 8'h81 at busy fall -> 2-cycle GAP, then a START with no sync -> tx bits 0,1,0,0,0,0,0,0,1,1; frame_done pulses 1 cycle at that byte's busy fall; the next byte is SYNC_BYTE.
REQ-032 Enable dropped 5 cycles into a sync byte -> both the sync byte and its data byte complete, busy falls once, then the module stays in IDLE with tx=1 indefinitely.
REQ-033 rst_n pulsed low in DATA bit 3 -> tx=1 and busy=0 within the same cycle (before the next clk edge); after release with enable=1 the next byte is 8'hA5.
REQ-034 Continuous enable over 3 frames -> exactly 3 frame_done pulses, 6 busy falling edges, 9 bytes on tx, and each data byte equal to the data value present at GAP exit.
